// File: rtl/cryptkey_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, owner identity and the
// application RAM word address width.
package cryptkey_pkg;

    localparam int RAM_ADDR_WIDTH = 15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT,
        RESP  = ST_RESP
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single application RAM port between the CPU and a DMA requester,
// round-robin on contention, with a per-access timeout and sticky error flag.
module ram_arbiter
    import cryptkey_pkg::*;
#(
    parameter int ADDR_WIDTH     = RAM_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_valid,
    input  logic [3:0]            cpu_wstrb,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_ready,
    output logic [31:0]           cpu_rdata,
    input  logic                  dma_valid,
    input  logic [3:0]            dma_wstrb,
    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic [31:0]           dma_wdata,
    output logic                  dma_ready,
    output logic [31:0]           dma_rdata,
    output logic                  ram_cs,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           ram_write_data,
    input  logic [31:0]           ram_read_data,
    input  logic                  ram_ready,
    input  logic                  error_clear,
    output logic                  bus_error,
    output logic                  error_src
);

    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    arb_state_t            r_state;
    logic                  r_owner;
    logic                  r_last_grant;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [7:0]            r_wait_cnt;
    logic [31:0]           r_cpu_rdata;
    logic [31:0]           r_dma_rdata;
    logic                  r_bus_error;
    logic                  r_error_src;
    logic                  w_pick;

    // On a tie the port that did not win last time gets the grant.
    function automatic logic pick_owner(input logic cpu_v, input logic dma_v, input logic last);
        return (cpu_v && dma_v) ? ~last : dma_v;
    endfunction

    assign w_pick = pick_owner(cpu_valid, dma_valid, r_last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_CPU;
            r_last_grant <= OWNER_DMA;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_wait_cnt   <= '0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_bus_error  <= 1'b0;
            r_error_src  <= 1'b0;
        end else begin
            // The timeout branch below is later in the block, so a set wins over a clear.
            if (error_clear) begin
                r_bus_error <= 1'b0;
                r_error_src <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (cpu_valid || dma_valid) begin
                        r_owner      <= w_pick;
                        r_last_grant <= w_pick;
                        r_addr       <= (w_pick == OWNER_DMA) ? dma_address : cpu_address;
                        r_wdata      <= (w_pick == OWNER_DMA) ? dma_wdata   : cpu_wdata;
                        r_wstrb      <= (w_pick == OWNER_DMA) ? dma_wstrb   : cpu_wstrb;
                        r_wait_cnt   <= '0;
                        r_state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (ram_ready) begin
                        if (r_owner == OWNER_DMA) r_dma_rdata <= ram_read_data;
                        else                      r_cpu_rdata <= ram_read_data;
                        r_state <= RESP;
                    end else if (r_wait_cnt == LP_WAIT_LAST) begin
                        if (r_owner == OWNER_DMA) r_dma_rdata <= 32'h0;
                        else                      r_cpu_rdata <= 32'h0;
                        r_bus_error <= 1'b1;
                        r_error_src <= r_owner;
                        r_state     <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_cs         = (r_state == GRANT);
    assign ram_we         = (r_state == GRANT) ? r_wstrb : 4'h0;
    assign ram_address    = r_addr;
    assign ram_write_data = r_wdata;
    assign cpu_ready      = (r_state == RESP) && (r_owner == OWNER_CPU);
    assign dma_ready      = (r_state == RESP) && (r_owner == OWNER_DMA);
    assign cpu_rdata      = r_cpu_rdata;
    assign dma_rdata      = r_dma_rdata;
    assign bus_error      = r_bus_error;
    assign error_src      = r_error_src;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected responses, a
// monitor pops and compares whenever a ready pulse appears.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid, dma_valid;
    logic [3:0]  cpu_wstrb, dma_wstrb;
    logic [14:0] cpu_address, dma_address;
    logic [31:0] cpu_wdata, dma_wdata;
    logic        cpu_ready, dma_ready;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        ram_cs;
    logic [3:0]  ram_we;
    logic [14:0] ram_address;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data = 32'h0;
    logic        ram_ready = 1'b0;
    logic        error_clear;
    logic        bus_error, error_src;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    logic        ram_en    = 1'b1;
    logic        chk_grant = 1'b0;
    logic [3:0]  exp_we;
    logic [14:0] exp_addr;
    logic [31:0] exp_wdata;

    ram_arbiter #(.ADDR_WIDTH(15), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_wstrb(cpu_wstrb), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dma_valid(dma_valid), .dma_wstrb(dma_wstrb), .dma_address(dma_address),
        .dma_wdata(dma_wdata), .dma_ready(dma_ready), .dma_rdata(dma_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .ram_ready(ram_ready), .error_clear(error_clear),
        .bus_error(bus_error), .error_src(error_src)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_of(input logic [14:0] a);
        return (a == 15'h0010) ? 32'hDEADBEEF : {16'hC0DE, 1'b0, a};
    endfunction

    // One-cycle RAM: ready the cycle after cs is first seen; ram_en=0 models a hung RAM.
    always @(posedge clk) begin
        ram_ready     <= ram_en && ram_cs && !ram_ready;
        ram_read_data <= rd_of(ram_address);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on every ready pulse, plus GRANT-phase bus checks.
    always @(negedge clk) begin
        if (cpu_ready || dma_ready) begin
            if (cpu_ready && dma_ready) check("both_ready", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ready", {30'd0, dma_ready, cpu_ready}, 32'd0);
            end else begin
                automatic exp_t e = exp_q.pop_front();
                check("resp_port", {31'd0, dma_ready}, {31'd0, e.port});
                check("resp_rdata", e.port ? dma_rdata : cpu_rdata, e.rdata);
            end
        end
        if (chk_grant && ram_cs) begin
            check("grant_we", {28'd0, ram_we}, {28'd0, exp_we});
            check("grant_addr", {17'd0, ram_address}, {17'd0, exp_addr});
            check("grant_wdata", ram_write_data, exp_wdata);
        end
    end

    task automatic req(input logic port, input logic [14:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, output int lat);
        logic done;
        @(negedge clk);
        if (port) begin
            dma_valid = 1'b1; dma_address = addr; dma_wstrb = wstrb; dma_wdata = wdata;
        end else begin
            cpu_valid = 1'b1; cpu_address = addr; cpu_wstrb = wstrb; cpu_wdata = wdata;
        end
        lat = 0;
        done = 1'b0;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (port ? dma_ready : cpu_ready) done = 1'b1;
        end
        if (!done) check(port ? "dma_wait_bound" : "cpu_wait_bound", 32'd0, 32'd1);
        if (port) dma_valid = 1'b0;
        else      cpu_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int lat_a, lat_b;

    initial begin
        rst_n = 1'b0; error_clear = 1'b0;
        cpu_valid = 1'b0; cpu_wstrb = 4'h0; cpu_address = '0; cpu_wdata = '0;
        dma_valid = 1'b0; dma_wstrb = 4'h0; dma_address = '0; dma_wdata = '0;
        exp_we = 4'h0; exp_addr = '0; exp_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {30'd0, dma_ready, cpu_ready}, 32'd0);
        check("rst_cs_we", {27'd0, ram_cs, ram_we}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_dma_rdata", dma_rdata, 32'd0);
        check("rst_err", {30'd0, bus_error, error_src}, 32'd0);
        check("rst_addr_data", ram_write_data | {17'd0, ram_address}, 32'd0);
        rst_n = 1'b1;

        // CPU read of 0x0010 completes at c3 with DEADBEEF
        chk_grant = 1'b1; exp_we = 4'h0; exp_addr = 15'h0010; exp_wdata = 32'h0;
        exp_q.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
        req(1'b0, 15'h0010, 4'h0, 32'h0, lat_a);
        check("cpu_read_latency", lat_a, 32'd3);

        // DMA full-word write to the top address
        exp_we = 4'hF; exp_addr = 15'h7FFF; exp_wdata = 32'h12345678;
        exp_q.push_back('{port: 1'b1, rdata: 32'hC0DE7FFF});
        req(1'b1, 15'h7FFF, 4'hF, 32'h12345678, lat_a);
        check("dma_write_latency", lat_a, 32'd3);
        chk_grant = 1'b0;

        // Contention right after reset: CPU, DMA, CPU, DMA
        do_reset();
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back('{port: 1'b0, rdata: 32'hC0DE0100 + r});
            exp_q.push_back('{port: 1'b1, rdata: 32'hC0DE0200 + r});
            fork
                req(1'b0, 15'h0100 + 15'(r), 4'h0, 32'h0, lat_a);
                req(1'b1, 15'h0200 + 15'(r), 4'h0, 32'h0, lat_b);
            join
            check("tie_cpu_latency", lat_a, 32'd3);
            check("tie_dma_latency", lat_b, 32'd7);
        end

        // Timeout on a DMA read with a hung RAM
        check("no_error_yet", {31'd0, bus_error}, 32'd0);
        ram_en = 1'b0;
        exp_q.push_back('{port: 1'b1, rdata: 32'h0});
        req(1'b1, 15'h0042, 4'h0, 32'h0, lat_a);
        check("timeout_latency", lat_a, 32'd17);
        check("timeout_bus_error", {31'd0, bus_error}, 32'd1);
        check("timeout_error_src", {31'd0, error_src}, 32'd1);
        ram_en = 1'b1;
        @(negedge clk);
        check("error_sticky", {31'd0, bus_error}, 32'd1);
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        check("error_cleared", {30'd0, bus_error, error_src}, 32'd0);

        // Async reset in the middle of a hung CPU write
        ram_en = 1'b0;
        cpu_valid = 1'b1; cpu_address = 15'h0055; cpu_wstrb = 4'h3; cpu_wdata = 32'hAABBCCDD;
        repeat (3) @(negedge clk);
        check("mid_grant_cs_we", {27'd0, ram_cs, ram_we}, {27'd0, 1'b1, 4'h3});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cs_we", {27'd0, ram_cs, ram_we}, 32'd0);
        check("async_rst_ready", {30'd0, dma_ready, cpu_ready}, 32'd0);
        cpu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ram_en = 1'b1;
        exp_q.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
        req(1'b0, 15'h0010, 4'h0, 32'h0, lat_a);
        check("post_reset_latency", lat_a, 32'd3);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
